clk_enable_gen: RTL

Cascaded clock-enable generator for the radio datapath. Divides the single sample clock into STAGES nested, phase-aligned single-cycle enables (e.g. 48 MHz CIC stage, 960 kHz base-band, 32 kHz audio), replacing ad-hoc per-rate free-running counters. Every enable of stage k coincides with an enable of stage k-1, so decimation stages never see skewed strobes. Divide ratios are parameters, optionally reprogrammable at run time with glitch-free switching at frame boundaries.

---
 rtl/clk_enable_gen_pkg.sv | 14 +
 rtl/clk_enable_gen_if.sv | 25 ++
 rtl/clk_enable_gen_enable_stage.sv | 41 ++++
 rtl/clk_enable_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/clk_enable_gen_pkg.sv
// rtl/clk_enable_gen_pkg.sv - default ratios, widths and word type for the clock-enable generator
package clk_enable_gen_pkg;

    localparam int STAGES_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    // CIC stage, base-band and audio ratios, each relative to the previous stage
    localparam int R1A = 5;
    localparam int R1B = 50;
    localparam int R2  = 30;

    typedef logic [CNT_W_DEF-1:0] word_t;

endpackage

// File: rtl/clk_enable_gen_if.sv
// rtl/clk_enable_gen_if.sv - enable/phase/reload bundle between generator and its user
// Signals: sync (restart), en (per-stage strobes), phase (per-stage counters);
// with RATIO_RELOAD_EN also div_i, div_load, load_pending.
// master = controlling side, slave = clk_enable_gen.
interface clk_enable_gen_if #(
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
);
    logic                    sync;
    logic [STAGES-1:0]       en;
    logic [STAGES*CNT_W-1:0] phase;
`ifdef RATIO_RELOAD_EN
    logic [STAGES*CNT_W-1:0] div_i;
    logic                    div_load;
    logic                    load_pending;

    modport master (output sync, output div_i, output div_load,
                    input en, input phase, input load_pending);
    modport slave  (input sync, input div_i, input div_load,
                    output en, output phase, output load_pending);
`else
    modport master (output sync, input en, input phase);
    modport slave  (input sync, output en, output phase);
`endif
endinterface

// File: rtl/clk_enable_gen_enable_stage.sv
// rtl/clk_enable_gen_enable_stage.sv - one divide stage of the cascaded enable generator
// Ports: clk, reset (async, high), sync (restart), tick_i (previous stage wrap),
// eff_i (effective ratio, >= 1), tick_o (this stage wraps on this edge), count_o.
module enable_stage
    import clk_enable_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] eff_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    // eff_i is never zero, so the subtraction cannot underflow
    assign wrap   = (cnt_q == eff_i - CNT_W'(1));
    assign tick_o = tick_i & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (sync)
            cnt_d = '0;
        else if (tick_i)
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - cascaded, phase-aligned clock-enable generator
// Ports: clk, reset (async, high), bus (clk_enable_gen_if.slave: sync, en, phase,
// and with macro RATIO_RELOAD_EN also div_i, div_load, load_pending).
// Without RATIO_RELOAD_EN the ratios are the constant DIV parameter.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int STAGES       = STAGES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DIV [STAGES] = '{R1A, R1B, R2}
) (
    input  logic            clk,
    input  logic            reset,
    clk_enable_gen_if.slave bus
);
    // tick[0] is the always-true input of stage 0; tick[k+1] is stage k's wrap
    logic [STAGES:0]              tick;
    logic [STAGES-1:0][CNT_W-1:0] div_def;
    logic [STAGES-1:0][CNT_W-1:0] d_act;
    logic [STAGES-1:0][CNT_W-1:0] eff;
    logic [STAGES-1:0][CNT_W-1:0] cnt;
    logic [STAGES-1:0]            en_q, en_d;

    assign tick[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            assign div_def[k] = CNT_W'(DIV[k]);
            // a programmed ratio of 0 behaves as pass-through
            assign eff[k] = (d_act[k] == '0) ? CNT_W'(1) : d_act[k];

            enable_stage #(
                .CNT_W (CNT_W)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .sync    (bus.sync),
                .tick_i  (tick[k]),
                .eff_i   (eff[k]),
                .tick_o  (tick[k+1]),
                .count_o (cnt[k])
            );
        end
    endgenerate

`ifdef RATIO_RELOAD_EN
    logic [STAGES-1:0][CNT_W-1:0] d_q, d_d;
    logic [STAGES-1:0][CNT_W-1:0] shadow_q, shadow_d;
    logic                         pending_q, pending_d;
    logic                         apply;

    // New ratios only take over when every counter is about to be zero
    // (top-stage wrap or sync), so no stage ever sees a truncated period.
    always_comb begin
        apply     = pending_q & (bus.sync | tick[STAGES]);
        d_d       = apply ? shadow_q : d_q;
        shadow_d  = bus.div_load ? bus.div_i : shadow_q;
        pending_d = bus.div_load | (pending_q & ~apply);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q       <= div_def;
            shadow_q  <= div_def;
            pending_q <= 1'b0;
        end else begin
            d_q       <= d_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign d_act            = d_q;
    assign bus.load_pending = pending_q;
`else
    assign d_act = div_def;
`endif

    assign en_d = bus.sync ? '0 : tick[STAGES:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            en_q <= '0;
        else
            en_q <= en_d;
    end

    assign bus.en    = en_q;
    assign bus.phase = cnt;

endmodule
